// File: rtl/decode_operand_unit_pkg.sv
// Shared constants and helpers for the decode-stage operand path.
// Forwarding buses are flat vectors; slice_lo gives the low bit of source i.
package decode_operand_unit_pkg;

    localparam int LOAD_LAT_MAX = 7;
    localparam int SB_CNT_W     = 3;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/decode_operand_unit_if.sv
// Decode-side issue handshake and decode->execute pipeline register outputs.
// The slave modport is the operand unit; the master is whoever feeds and drains it.
interface decode_operand_unit_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     rs1_sel;
    logic [AW-1:0]     rs2_sel;
    logic              rs1_used;
    logic              rs2_used;
    logic [AW-1:0]     rd_sel;
    logic              rd_write;
    logic              rd_is_load;
    logic              epc_read;
    logic              stall_load;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs1_data;
    logic [DATA_W-1:0] out_rs2_data;
    logic [AW-1:0]     out_rd_sel;
    logic              out_rd_write;
    logic              out_rd_is_load;

    modport master (
        output in_valid, rs1_sel, rs2_sel, rs1_used, rs2_used,
               rd_sel, rd_write, rd_is_load, epc_read, out_ready,
        input  in_ready, stall_load, out_valid, out_rs1_data, out_rs2_data,
               out_rd_sel, out_rd_write, out_rd_is_load
    );

    modport slave (
        input  in_valid, rs1_sel, rs2_sel, rs1_used, rs2_used,
               rd_sel, rd_write, rd_is_load, epc_read, out_ready,
        output in_ready, stall_load, out_valid, out_rs1_data, out_rs2_data,
               out_rd_sel, out_rd_write, out_rd_is_load
    );

endinterface

// File: rtl/decode_operand_unit_operand_resolve.sv
// Combinational operand source select: EPC, then youngest matching forward,
// then writeback bypass, then register file contents.
module operand_resolve
    import decode_operand_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AW     = 3,
    parameter int NFWD   = 3
) (
    input  logic [AW-1:0]          sel,
    input  logic                   epc_en,
    input  logic [DATA_W-1:0]      epc,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*AW-1:0]     fwd_sel,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_sel,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [DATA_W-1:0]      rf_data,
    output logic [DATA_W-1:0]      data
);

    always_comb begin
        data = rf_data;
        if (wb_en && (wb_sel == sel)) begin
            data = wb_data;
        end
        // Walk oldest to youngest so the lowest matching index wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_sel[slice_lo(i, AW) +: AW] == sel)) begin
                data = fwd_data[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
        if (epc_en) begin
            data = epc;
        end
    end

endmodule

// File: rtl/decode_operand_unit.sv
// Decode operand unit: register file, EPC, load scoreboard interlock and the
// valid/ready decode->execute pipeline register.
module decode_operand_unit
    import decode_operand_unit_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NREGS    = 8,
    parameter  int NFWD     = 3,
    parameter  int LOAD_LAT = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    decode_operand_unit_if.slave   bus,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*AW-1:0]     fwd_sel,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_sel,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   epc_capture,
    input  logic                   flush
);

    localparam int LOAD_LAT_C = (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
    localparam logic [SB_CNT_W-1:0] LOAD_CNT = SB_CNT_W'(LOAD_LAT_C);

    logic [DATA_W-1:0]   rf     [NREGS];
    logic [SB_CNT_W-1:0] sb_cnt [NREGS];
    logic [DATA_W-1:0]   epc;

    logic [DATA_W-1:0]   rs1_val;
    logic [DATA_W-1:0]   rs2_val;
    logic                rs1_hazard;
    logic                rs2_hazard;
    logic                hazard;
    logic                accept;
    logic                load_issue;

    logic                out_valid_q;
    logic [DATA_W-1:0]   out_rs1_q;
    logic [DATA_W-1:0]   out_rs2_q;
    logic [AW-1:0]       out_rd_sel_q;
    logic                out_rd_write_q;
    logic                out_rd_is_load_q;

    // An RTI-type read of EPC does not touch rs1, so it cannot be load-blocked.
    assign rs1_hazard = bus.rs1_used && !bus.epc_read && (sb_cnt[bus.rs1_sel] != '0);
    assign rs2_hazard = bus.rs2_used && (sb_cnt[bus.rs2_sel] != '0);
    assign hazard     = rs1_hazard || rs2_hazard;

    assign bus.in_ready   = !hazard && (!out_valid_q || bus.out_ready) && !flush;
    assign bus.stall_load = bus.in_valid && hazard && !flush;
    assign accept         = bus.in_valid && bus.in_ready;
    assign load_issue     = accept && bus.rd_write && bus.rd_is_load;

    operand_resolve #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .NFWD   (NFWD)
    ) u_rs1_resolve (
        .sel       (bus.rs1_sel),
        .epc_en    (bus.epc_read),
        .epc       (epc),
        .fwd_valid (fwd_valid),
        .fwd_sel   (fwd_sel),
        .fwd_data  (fwd_data),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .rf_data   (rf[bus.rs1_sel]),
        .data      (rs1_val)
    );

    operand_resolve #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .NFWD   (NFWD)
    ) u_rs2_resolve (
        .sel       (bus.rs2_sel),
        .epc_en    (1'b0),
        .epc       (epc),
        .fwd_valid (fwd_valid),
        .fwd_sel   (fwd_sel),
        .fwd_data  (fwd_data),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .rf_data   (rf[bus.rs2_sel]),
        .data      (rs2_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                rf[r] <= '0;
            end
            epc <= '0;
        end else begin
            if (wb_en) begin
                rf[wb_sel] <= wb_data;
            end
            if (epc_capture) begin
                epc <= wb_data;
            end
        end
    end

    // A fresh load reloads its counter even if one is already in flight;
    // flush leaves the counters alone, costing only extra stall cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (load_issue && (bus.rd_sel == AW'(r))) begin
                    sb_cnt[r] <= LOAD_CNT;
                end else if (sb_cnt[r] != '0) begin
                    sb_cnt[r] <= sb_cnt[r] - SB_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q      <= 1'b0;
            out_rs1_q        <= '0;
            out_rs2_q        <= '0;
            out_rd_sel_q     <= '0;
            out_rd_write_q   <= 1'b0;
            out_rd_is_load_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q      <= 1'b1;
            out_rs1_q        <= rs1_val;
            out_rs2_q        <= rs2_val;
            out_rd_sel_q     <= bus.rd_sel;
            out_rd_write_q   <= bus.rd_write;
            out_rd_is_load_q <= bus.rd_is_load;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_rs1_data   = out_rs1_q;
    assign bus.out_rs2_data   = out_rs2_q;
    assign bus.out_rd_sel     = out_rd_sel_q;
    assign bus.out_rd_write   = out_rd_write_q;
    assign bus.out_rd_is_load = out_rd_is_load_q;

endmodule

// File: tb/tb_decode_operand_unit.sv
// Self-checking bench for decode_operand_unit: vector table, directed hazard /
// backpressure / flush / EPC sequences, then random traffic against a reference model.
module tb_decode_operand_unit;

    localparam int DATA_W   = 16;
    localparam int NREGS    = 8;
    localparam int AW       = 3;
    localparam int NFWD     = 3;
    localparam int LOAD_LAT = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD*AW-1:0]     fwd_sel;
    logic [NFWD*DATA_W-1:0] fwd_data;
    logic                   wb_en;
    logic [AW-1:0]          wb_sel;
    logic [DATA_W-1:0]      wb_data;
    logic                   epc_capture;
    logic                   flush;

    int total = 0;
    int bad   = 0;

    decode_operand_unit_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    decode_operand_unit #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .NFWD     (NFWD),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .fwd_valid   (fwd_valid),
        .fwd_sel     (fwd_sel),
        .fwd_data    (fwd_data),
        .wb_en       (wb_en),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .epc_capture (epc_capture),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0]        fv;
        logic [AW-1:0]     fs0;
        logic [AW-1:0]     fs1;
        logic [AW-1:0]     fs2;
        logic              wben;
        logic [AW-1:0]     wbsel;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
        logic              er;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } vec_t;

    vec_t vecs [6];

    // reference model state
    logic [DATA_W-1:0] m_rf [NREGS];
    int                busy_until [NREGS];
    logic [DATA_W-1:0] m_epc;
    logic              m_valid;
    logic [DATA_W-1:0] m_rs1, m_rs2;
    logic [AW-1:0]     m_rd;
    logic              m_wr, m_ld;
    int                cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.rs1_sel    = '0;
        bus.rs2_sel    = '0;
        bus.rs1_used   = 1'b0;
        bus.rs2_used   = 1'b0;
        bus.rd_sel     = '0;
        bus.rd_write   = 1'b0;
        bus.rd_is_load = 1'b0;
        bus.epc_read   = 1'b0;
        bus.out_ready  = 1'b1;
        fwd_valid      = '0;
        fwd_sel        = '0;
        fwd_data       = '0;
        wb_en          = 1'b0;
        wb_sel         = '0;
        wb_data        = '0;
        epc_capture    = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] r1, input logic u1, input logic [AW-1:0] r2,
                         input logic u2, input logic [AW-1:0] rd, input logic wr,
                         input logic ld, input logic er);
        bus.in_valid   = 1'b1;
        bus.rs1_sel    = r1;
        bus.rs1_used   = u1;
        bus.rs2_sel    = r2;
        bus.rs2_used   = u2;
        bus.rd_sel     = rd;
        bus.rd_write   = wr;
        bus.rd_is_load = ld;
        bus.epc_read   = er;
    endtask

    function automatic logic [DATA_W-1:0] ref_operand(input logic [AW-1:0] sel, input logic use_epc);
        if (use_epc) return m_epc;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_valid[i] && fwd_sel[i*AW +: AW] == sel) return fwd_data[i*DATA_W +: DATA_W];
        end
        if (wb_en && wb_sel == sel) return wb_data;
        return m_rf[sel];
    endfunction

    initial begin
        int stalls, not_ready, got;
        logic hz, exp_ready, exp_stall, acc;
        logic [DATA_W-1:0] r1v, r2v;

        //           fv      fs0   fs1   fs2   wben  wbsel rs1   rs2   er    e1        e2
        vecs[0] = '{3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd3, 3'd6, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{3'b111, 3'd2, 3'd6, 3'd2, 1'b1, 3'd2, 3'd2, 3'd6, 1'b0, 16'h1111, 16'h2222};
        vecs[2] = '{3'b110, 3'd2, 3'd6, 3'd2, 1'b1, 3'd2, 3'd2, 3'd6, 1'b0, 16'h3333, 16'h2222};
        vecs[3] = '{3'b010, 3'd2, 3'd6, 3'd2, 1'b1, 3'd2, 3'd2, 3'd6, 1'b0, 16'h4444, 16'h2222};
        vecs[4] = '{3'b000, 3'd2, 3'd6, 3'd2, 1'b0, 3'd2, 3'd2, 3'd6, 1'b0, 16'h4444, 16'h0000};
        vecs[5] = '{3'b001, 3'd2, 3'd6, 3'd2, 1'b0, 3'd2, 3'd2, 3'd2, 1'b1, 16'h0000, 16'h1111};

        // reset state
        rst = 1'b0;
        idle();
        #2;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // forwarding priority table
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            fwd_valid = vecs[k].fv;
            fwd_sel   = {vecs[k].fs2, vecs[k].fs1, vecs[k].fs0};
            fwd_data  = {16'h3333, 16'h2222, 16'h1111};
            wb_en     = vecs[k].wben;
            wb_sel    = vecs[k].wbsel;
            wb_data   = 16'h4444;
            issue(vecs[k].rs1, 1'b1, vecs[k].rs2, 1'b1, 3'd0, 1'b0, 1'b0, vecs[k].er);
            #1;
            chk($sformatf("vec%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_rs1", k), 32'(bus.out_rs1_data), 32'(vecs[k].e1));
            chk($sformatf("vec%0d_rs2", k), 32'(bus.out_rs2_data), 32'(vecs[k].e2));
        end

        // load-use interlock; unused rs2 does not stall; back-to-back reload
        @(negedge clk);
        idle();
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        issue(3'd0, 1'b1, 3'd5, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("unused_rs2_ready", 32'(bus.in_ready), 32'd1);
        chk("unused_rs2_stall", 32'(bus.stall_load), 32'd0);
        @(posedge clk);
        @(negedge clk);
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        issue(3'd0, 1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        stalls = 0; not_ready = 0; got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.in_ready) begin
                got = 1;
                break;
            end
            not_ready++;
            if (bus.stall_load) stalls++;
            @(negedge clk);
        end
        chk("loaduse_accepted", 32'(got), 32'd1);
        chk("loaduse_not_ready_cycles", 32'(not_ready), 32'd2);
        chk("loaduse_stall_cycles", 32'(stalls), 32'd2);
        @(posedge clk);

        // backpressure: sampled operand held while r1 is rewritten
        @(negedge clk);
        idle();
        wb_en = 1'b1; wb_sel = 3'd1; wb_data = 16'h00AA;
        issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_first_rs1", 32'(bus.out_rs1_data), 32'h00AA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            wb_en = 1'b1; wb_sel = 3'd1; wb_data = 16'h0BB0 + 16'(k);
            issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_rs1", 32'(bus.out_rs1_data), 32'h00AA);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        wb_en = 1'b0;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_next_rs1", 32'(bus.out_rs1_data), 32'h0BB3);
        chk("bp_next_rd", 32'(bus.out_rd_sel), 32'd3);

        // flush squashes output and input; scoreboard keeps counting
        @(negedge clk);
        idle();
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_load_out", 32'(bus.out_rd_is_load), 32'd1);
        @(negedge clk);
        issue(3'd0, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fl_stall", 32'(bus.stall_load), 32'd0);
        @(posedge clk);
        #1;
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        issue(3'd4, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fl_sb_stall", 32'(bus.stall_load), 32'd1);
        chk("fl_sb_not_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("fl_sb_done_ready", 32'(bus.in_ready), 32'd1);
        chk("fl_sb_done_stall", 32'(bus.stall_load), 32'd0);
        @(posedge clk);
        #1;
        chk("fl_sb_accept", 32'(bus.out_valid), 32'd1);

        // EPC capture / same-cycle read of old value / async reset
        @(negedge clk);
        idle();
        epc_capture = 1'b1; wb_data = 16'h0ABC;
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("epc_same_cycle_old", 32'(bus.out_rs1_data), 32'h0000);
        @(negedge clk);
        epc_capture = 1'b0;
        @(posedge clk);
        #1;
        chk("epc_read", 32'(bus.out_rs1_data), 32'h0ABC);
        chk("epc_out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("epc_after_rst", 32'(bus.out_rs1_data), 32'h0000);

        // random traffic against the reference model
        @(negedge clk);
        idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int r = 0; r < NREGS; r++) begin
            m_rf[r] = '0;
            busy_until[r] = -100;
        end
        m_epc = '0; m_valid = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wr = 1'b0; m_ld = 1'b0;
        cyc = 0;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_rs1", 32'(bus.out_rs1_data), 32'(m_rs1));
                chk("rnd_rs2", 32'(bus.out_rs2_data), 32'(m_rs2));
                chk("rnd_rd_sel", 32'(bus.out_rd_sel), 32'(m_rd));
                chk("rnd_rd_write", 32'(bus.out_rd_write), 32'(m_wr));
                chk("rnd_rd_is_load", 32'(bus.out_rd_is_load), 32'(m_ld));
            end
            issue(AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            fwd_valid     = NFWD'($urandom);
            fwd_sel       = (NFWD*AW)'($urandom);
            for (int i = 0; i < NFWD; i++) fwd_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            wb_en         = 1'($urandom_range(0, 1));
            wb_sel        = AW'($urandom_range(0, 7));
            wb_data       = DATA_W'($urandom);
            epc_capture   = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 11) == 0);
            #1;
            hz = (bus.rs1_used && !bus.epc_read && cyc <= busy_until[bus.rs1_sel]) ||
                 (bus.rs2_used && cyc <= busy_until[bus.rs2_sel]);
            exp_ready = !hz && (!m_valid || bus.out_ready) && !flush;
            exp_stall = bus.in_valid && hz && !flush;
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("rnd_stall_load", 32'(bus.stall_load), 32'(exp_stall));
            acc = bus.in_valid && exp_ready;
            r1v = ref_operand(bus.rs1_sel, bus.epc_read);
            r2v = ref_operand(bus.rs2_sel, 1'b0);
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_rs1 = r1v; m_rs2 = r2v;
                m_rd = bus.rd_sel; m_wr = bus.rd_write; m_ld = bus.rd_is_load;
            end else if (bus.out_ready) m_valid = 1'b0;
            if (acc && bus.rd_write && bus.rd_is_load) busy_until[bus.rd_sel] = cyc + LOAD_LAT;
            if (wb_en) m_rf[wb_sel] = wb_data;
            if (epc_capture) m_epc = wb_data;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
